// File: rtl/mode1_max_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mode1_max_ctrl
// Purpose  : Sequencer for the 4-lane FP16 max-reduction datapath (softmax
//            mode 1). Streams num_words packed words from the local buffer
//            into the max tree, feeding the running maximum back as the
//            tree's extra input, and returns the vector maximum.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            start           - begin a reduction (sampled only in IDLE)
//            base_addr       - first word address, sampled with start
//            num_words       - word count, sampled with start
//            rd_en, rd_addr  - buffer read strobe / address
//            rd_data         - read data, valid one cycle after rd_en
//            max_inp0..3     - rd_data lanes 0..3 to the datapath
//            max_ex_inp      - running maximum to the datapath extra input
//            max_outp        - datapath result
//            busy, done      - status; done is a one-cycle pulse
//            max_result      - final maximum, held until next accepted start
// Revision : 1.0 - initial release
// ============================================================================
module mode1_max_ctrl #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDRWIDTH-1:0]   base_addr,
  input  logic [ADDRWIDTH:0]     num_words,
  output logic                   rd_en,
  output logic [ADDRWIDTH-1:0]   rd_addr,
  input  logic [4*DATAWIDTH-1:0] rd_data,
  output logic [DATAWIDTH-1:0]   max_inp0,
  output logic [DATAWIDTH-1:0]   max_inp1,
  output logic [DATAWIDTH-1:0]   max_inp2,
  output logic [DATAWIDTH-1:0]   max_inp3,
  output logic [DATAWIDTH-1:0]   max_ex_inp,
  input  logic [DATAWIDTH-1:0]   max_outp,
  output logic                   busy,
  output logic                   done,
  output logic [DATAWIDTH-1:0]   max_result
);

  // FP16 negative infinity: identity element of the max reduction.
  localparam logic [DATAWIDTH-1:0] NEG_INF = DATAWIDTH'(16'hFC00);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [ADDRWIDTH:0]   count;     // words to reduce in this run
  logic [ADDRWIDTH:0]   issued;    // reads issued so far, including current
  logic                 rd_valid;  // rd_data carries a requested word
  logic [DATAWIDTH-1:0] run_max;

  assign max_inp0   = rd_data[0*DATAWIDTH +: DATAWIDTH];
  assign max_inp1   = rd_data[1*DATAWIDTH +: DATAWIDTH];
  assign max_inp2   = rd_data[2*DATAWIDTH +: DATAWIDTH];
  assign max_inp3   = rd_data[3*DATAWIDTH +: DATAWIDTH];
  assign max_ex_inp = run_max;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      max_result <= '0;
      run_max    <= NEG_INF;
      rd_valid   <= 1'b0;
      count      <= '0;
      issued     <= '0;
    end else begin
      rd_valid <= rd_en;
      done     <= 1'b0;
      // The datapath folds the current word into the running max
      // combinationally, so the register simply captures its output.
      if (rd_valid) begin
        run_max <= max_outp;
      end

      case (state)
        IDLE: begin
          if (start) begin
            run_max <= NEG_INF;
            busy    <= 1'b1;
            if (num_words == '0) begin
              state      <= DONE;
              done       <= 1'b1;
              max_result <= NEG_INF;
            end else begin
              state   <= READ;
              rd_en   <= 1'b1;
              rd_addr <= base_addr;  // rd_addr doubles as the latched base
              count   <= num_words;
              issued  <= {{ADDRWIDTH{1'b0}}, 1'b1};
            end
          end
        end

        READ: begin
          if (rd_en) begin
            if (issued == count) begin
              rd_en <= 1'b0;  // last word issued; one drain cycle follows
            end else begin
              rd_addr <= rd_addr + 1'b1;  // wraps modulo 2^ADDRWIDTH
              issued  <= issued + 1'b1;
            end
          end else begin
            // Drain cycle: the final word is in flight through the tree,
            // so take the result straight from the datapath output.
            state      <= DONE;
            done       <= 1'b1;
            max_result <= max_outp;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
